lfsr_prng: RTL and testbench

//  Parametrised Fibonacci LFSR pseudo-random generator; successor to the fixed 16-bit maze LFSR.

---
 rtl/lfsr_prng_if.sv | 22 ++
 rtl/lfsr_prng.sv | 86 ++++++++
 tb/tb_lfsr_prng.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/lfsr_prng_if.sv
// Control and observation bundle for lfsr_prng: seed/load/en in, state and wrap/period status out.
interface lfsr_prng_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] seed;
  logic             load;
  logic             en;
  logic [WIDTH-1:0] out;
  logic             seed_err;
  logic             wrap;
  logic [WIDTH-1:0] period;

  modport master (
    output seed, load, en,
    input  out, seed_err, wrap, period
  );

  modport slave (
    input  seed, load, en,
    output out, seed_err, wrap, period
  );
endinterface

// File: rtl/lfsr_prng.sv
// Parametrised Fibonacci LFSR with multi-step advance, guarded seed load and
// cycle-length measurement (wrap pulse + period of the last completed cycle).
module lfsr_prng #(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(16'hD008),
  parameter int unsigned      STEPS     = 1,
  parameter bit               XNOR      = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(16'h0001)
) (
  input  logic     clk,
  input  logic     rst,
  lfsr_prng_if.slave bus
);

  localparam logic [WIDTH-1:0] LOCKUP = XNOR ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] start;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] period;
  logic             seed_err;
  logic             wrap;

  logic [WIDTH-1:0] nxt_c;
  logic [WIDTH-1:0] cnt_inc_c;

  function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] s);
    logic fb;
    fb = (^(s & TAPS)) ^ XNOR;
    return {s[WIDTH-2:0], fb};
  endfunction

  // STEPS single shifts chained combinationally
  always_comb begin
    nxt_c = state;
    for (int unsigned i = 0; i < STEPS; i++) begin
      nxt_c = step1(nxt_c);
    end
  end

  // Saturating increment so an over-long cycle reports all ones
  always_comb begin
    cnt_inc_c = (cnt == {WIDTH{1'b1}}) ? cnt : cnt + WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RESET_VAL;
      start    <= RESET_VAL;
      cnt      <= '0;
      period   <= '0;
      seed_err <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      seed_err <= 1'b0;
      wrap     <= 1'b0;
      if (bus.load) begin
        cnt <= '0;
        // Lock-up seed would freeze the register; fall back to RESET_VAL
        if (bus.seed == LOCKUP) begin
          state    <= RESET_VAL;
          start    <= RESET_VAL;
          seed_err <= 1'b1;
        end else begin
          state <= bus.seed;
          start <= bus.seed;
        end
      end else if (bus.en) begin
        state <= nxt_c;
        if (nxt_c == start) begin
          wrap   <= 1'b1;
          period <= cnt_inc_c;
          cnt    <= '0;
        end else begin
          cnt <= cnt_inc_c;
        end
      end
    end
  end

  assign bus.out      = state;
  assign bus.seed_err = seed_err;
  assign bus.wrap     = wrap;
  assign bus.period   = period;

endmodule

// File: tb/tb_lfsr_prng.sv
// Directed-vector bench for lfsr_prng: default XNOR x1, a 4-step variant and an XOR variant.
module tb_lfsr_prng;

  logic clk;
  logic rst;

  int nvec;
  int nmis;

  lfsr_prng_if #(.WIDTH(16)) bus_d ();
  lfsr_prng_if #(.WIDTH(16)) bus_s4 ();
  lfsr_prng_if #(.WIDTH(16)) bus_x ();

  lfsr_prng u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_d)
  );

  lfsr_prng #(.STEPS(4)) u_s4 (
    .clk (clk),
    .rst (rst),
    .bus (bus_s4)
  );

  lfsr_prng #(.XNOR(1'b0), .RESET_VAL(16'h0001)) u_xor (
    .clk (clk),
    .rst (rst),
    .bus (bus_x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] seq1 [4];
  int          nwrap;
  int          first_wrap;

  initial begin
    nvec = 0;
    nmis = 0;
    seq1[0] = 16'h0003;
    seq1[1] = 16'h0007;
    seq1[2] = 16'h000F;
    seq1[3] = 16'h001E;

    rst = 1'b1;
    bus_d.seed = '0;  bus_d.load = 1'b0;  bus_d.en = 1'b0;
    bus_s4.seed = '0; bus_s4.load = 1'b0; bus_s4.en = 1'b0;
    bus_x.seed = '0;  bus_x.load = 1'b0;  bus_x.en = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_out", 32'(bus_d.out), 32'h0001);
    chk("rst_seed_err", 32'(bus_d.seed_err), 32'h0);
    chk("rst_wrap", 32'(bus_d.wrap), 32'h0);
    chk("rst_period", 32'(bus_d.period), 32'h0);

    // Scenario 1 plus single cycle on the 4-step and XOR variants
    bus_d.en = 1'b1;
    bus_s4.en = 1'b1;
    bus_x.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) begin
        chk("s4_step1", 32'(bus_s4.out), 32'h001E);
        chk("xor_step1", 32'(bus_x.out), 32'h0002);
        bus_x.en = 1'b0;
      end
      if (i == 1) begin
        chk("s4_step2", 32'(bus_s4.out), 32'h01E1);
        bus_s4.en = 1'b0;
      end
      chk($sformatf("seq1_%0d", i), 32'(bus_d.out), 32'(seq1[i]));
      chk($sformatf("seq1_wrap_%0d", i), 32'(bus_d.wrap), 32'h0);
      chk($sformatf("seq1_serr_%0d", i), 32'(bus_d.seed_err), 32'h0);
    end
    bus_d.en = 1'b0;

    // Scenario 5b: XOR lock-up seed rejected
    bus_x.seed = 16'h0000;
    bus_x.load = 1'b1;
    tick();
    bus_x.load = 1'b0;
    chk("xor_lock_out", 32'(bus_x.out), 32'h0001);
    chk("xor_lock_serr", 32'(bus_x.seed_err), 32'h1);
    tick();
    chk("xor_serr_pulse", 32'(bus_x.seed_err), 32'h0);

    // Scenario 2: full maximal-length cycle from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus_d.en = 1'b1;
    nwrap = 0;
    first_wrap = 0;
    for (int i = 1; i <= 65535; i++) begin
      tick();
      if (bus_d.wrap) begin
        nwrap++;
        if (first_wrap == 0) first_wrap = i;
      end
    end
    bus_d.en = 1'b0;
    chk("full_nwrap", 32'(nwrap), 32'd1);
    chk("full_wrap_cycle", 32'(first_wrap), 32'd65535);
    chk("full_out", 32'(bus_d.out), 32'h0001);
    chk("full_period", 32'(bus_d.period), 32'hFFFF);
    tick();
    chk("full_wrap_pulse", 32'(bus_d.wrap), 32'h0);
    chk("full_period_hold", 32'(bus_d.period), 32'hFFFF);

    // Scenario 3: lock-up seed on XNOR, then a legal seed
    bus_d.seed = 16'hFFFF;
    bus_d.load = 1'b1;
    tick();
    chk("lock_out", 32'(bus_d.out), 32'h0001);
    chk("lock_serr", 32'(bus_d.seed_err), 32'h1);
    chk("lock_period_kept", 32'(bus_d.period), 32'hFFFF);
    bus_d.seed = 16'hACE1;
    tick();
    bus_d.load = 1'b0;
    chk("ace1_out", 32'(bus_d.out), 32'hACE1);
    chk("ace1_serr", 32'(bus_d.seed_err), 32'h0);

    // Scenario 4: load beats en, then hold, then one step
    bus_d.seed = 16'h1234;
    bus_d.load = 1'b1;
    bus_d.en = 1'b1;
    tick();
    bus_d.load = 1'b0;
    bus_d.en = 1'b0;
    chk("load_pri_out", 32'(bus_d.out), 32'h1234);
    for (int i = 0; i < 10; i++) tick();
    chk("hold_out", 32'(bus_d.out), 32'h1234);
    chk("hold_wrap", 32'(bus_d.wrap), 32'h0);
    bus_d.en = 1'b1;
    tick();
    bus_d.en = 1'b0;
    chk("step_1234", 32'(bus_d.out), 32'h2468);

    // Scenario 6: asynchronous reset between edges
    bus_d.en = 1'b1;
    tick();
    tick();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_out", 32'(bus_d.out), 32'h0001);
    chk("async_period", 32'(bus_d.period), 32'h0);
    bus_d.en = 1'b0;
    tick();
    rst = 1'b0;
    bus_d.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post_rst_%0d", i), 32'(bus_d.out), 32'(seq1[i]));
    end
    bus_d.en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
